sr_ff_excitation_driver: RTL and testbench
==========================================

# sr_ff_excitation_driver

Command-driven excitation sequencer that drives the S/R inputs of an SR flip-flop and closes the loop on its Q output. It accepts set/reset/toggle/hold commands over a valid/ready handshake. For each command it issues a single-cycle, never-forbidden S/R pulse, waits for the flip-flop to settle, and checks Q. On a mismatch it retries a bounded number of times before flagging an error. It sits between control logic and any SR flip-flop instance in the design, acting as the only legal writer of that flop's S/R pins.

## Interface
- SETTLE_CYCLES, 2, cycles waited after each S/R pulse before Q_Fb_In is checked; legal range 1..15.
- MAX_RETRY, 3, extra attempts after a failed check; legal range 0..7.

- Clk_In  input  1  clock; all state changes on rising edge.
- Reset_In  input  1  asynchronous, active-low reset.
- Cmd_Valid_In  input  1  command present.
- Cmd_Op_In  input  2  00 hold, 01 reset (Q→0), 10 set (Q→1), 11 toggle (Q→~Q).
- Cmd_Ready_Out  output  1  high only in IDLE.
- Q_Fb_In  input  1  Q output of the driven flip-flop.
- S_Out  output  1  flip-flop set drive.
- R_Out  output  1  flip-flop reset drive.
- Busy_Out  output  1  high in any state other than IDLE.
- Done_Out  output  1  one-cycle pulse: command completed, Q matches target.
- Error_Out  output  1  one-cycle pulse: retries exhausted, Q mismatched.
- Retry_Count_Out  output  3  attempts beyond the first for the last completed command; held until the next completion.

## Operation
- Reset values: S_Out=0, R_Out=0, Busy_Out=0, Done_Out=0, Error_Out=0, Retry_Count_Out=0, state IDLE, Cmd_Ready_Out=1.
- Reset asserted mid-command aborts immediately with no Done/Error pulse. S/R drop to 0 asynchronously.
- The FSM has four states: IDLE, DRIVE, WAIT, CHECK.
- **IDLE**
  - Cmd_Ready_Out=1.
  - When Cmd_Valid_In && Cmd_Ready_Out at a rising edge, latch the target and go to DRIVE, with the attempt counter cleared.
  - Target: hold → Q_Fb_In sampled at accept; reset → 0; set → 1; toggle → ~Q_Fb_In sampled at accept.
- **DRIVE**
  - Lasts exactly one cycle, then goes to WAIT.
  - Target=1 drives S_Out=1, R_Out=0. Target=0 drives S_Out=0, R_Out=1.
  - A hold command drives S_Out=R_Out=0.
  - S_Out and R_Out are never both 1, in any state, including during reset.
- **WAIT**
  - Lasts SETTLE_CYCLES cycles with S_Out=R_Out=0, then goes to CHECK.
- **CHECK**
  - Lasts one cycle and compares Q_Fb_In to the latched target.
  - Match → IDLE, with a Done_Out pulse.
  - Mismatch and attempt counter < MAX_RETRY → increment counter, back to DRIVE.
  - Mismatch and counter == MAX_RETRY → IDLE, with an Error_Out pulse.
  - Retry_Count_Out takes the counter value on either exit.
- Toggle retries re-drive the target latched at accept; the toggle is never re-evaluated against the current Q.
- Cmd_Op_In and Q_Fb_In are ignored outside IDLE and CHECK. Changes on Cmd_Op_In after accept have no effect.
- Done_Out and Error_Out are never high in the same cycle.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Let the accept edge be e0.
  - S/R pulse is high from e0 to e1.
  - WAIT spans e1 to e(1+SETTLE_CYCLES).
  - CHECK spans the next cycle.
- On first-pass success, Done_Out is high from e(2+SETTLE_CYCLES) to e(3+SETTLE_CYCLES). Cmd_Ready_Out rises at the same edge.
- Each retry adds 2+SETTLE_CYCLES cycles.
- Worst-case latency from accept to Error_Out is (MAX_RETRY+1)·(2+SETTLE_CYCLES) cycles.
- Back-to-back commands: a command valid in the cycle Done/Error is high is accepted at the next edge. Throughput is therefore one command per 2+SETTLE_CYCLES+1 cycles minimum.
- The driven flip-flop samples S/R on the falling edge. The one-cycle pulse from DRIVE therefore covers exactly one sampling edge.

## Test plan
- **Set from reset:** release reset with Q_Fb_In=0, SETTLE=2; issue op 10, and a flop model sets Q. Required: S_Out=1 for exactly one cycle after accept, R_Out=0 throughout, Done_Out pulses at e4, Retry_Count_Out=0.
- **Toggle then hold:** with Q=1, issue op 11. Required: R_Out pulse and Done_Out. Then issue op 00. Required: no S/R activity and Done_Out at e4.
- **Stuck flop, MAX_RETRY=3:** force Q_Fb_In=0 and issue op 10. Required: four S_Out pulses spaced 4 cycles apart, Error_Out at e16, Retry_Count_Out=3, no Done_Out.
- **Recovery on retry:** Q_Fb_In fails the first check and then follows S. Required: exactly two S_Out pulses, Done_Out, Retry_Count_Out=1.
- **Reset mid-WAIT:** drop Reset_In during WAIT. Required: all outputs return to reset values immediately, no Done/Error, Cmd_Ready_Out=1 after release.
- **Invariant check:** run random commands with random Q feedback for 10k cycles. Required: S_Out&R_Out never 1, Done_Out&Error_Out never 1, Cmd_Ready_Out==~Busy_Out in every cycle.

Source files
------------

// File: rtl/sr_ff_excitation_driver.sv
// sr_ff_excitation_driver
// Closed-loop sequencer that is the only writer of an SR flip-flop's S/R pins.
// Each accepted command becomes a one-cycle S or R pulse. The sequencer then
// waits for the flop to settle and compares its Q against the latched target.
// A mismatch re-drives the same target, up to MAX_RETRY extra times, before
// an error is reported.
module sr_ff_excitation_driver #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 3
) (
    input  logic       Clk_In,
    input  logic       Reset_In,
    input  logic       Cmd_Valid_In,
    input  logic [1:0] Cmd_Op_In,
    output logic       Cmd_Ready_Out,
    input  logic       Q_Fb_In,
    output logic       S_Out,
    output logic       R_Out,
    output logic       Busy_Out,
    output logic       Done_Out,
    output logic       Error_Out,
    output logic [2:0] Retry_Count_Out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK
    } state_t;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic [2:0] attempt, attempt_nxt;
    logic       target, target_nxt;
    logic       hold_cmd, hold_cmd_nxt;
    logic       s_nxt, r_nxt;
    logic       done_nxt, error_nxt;
    logic [2:0] retry_nxt;
    logic       accept_target;

    // Ready and busy come straight from the state register, so they stay
    // registered and are always exact complements of each other.
    assign Cmd_Ready_Out = (state == ST_IDLE);
    assign Busy_Out      = (state != ST_IDLE);

    // State, sequencing counters and all registered outputs; reset clears the
    // drive pins asynchronously so S and R can never be left asserted.
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            attempt         <= '0;
            target          <= 1'b0;
            hold_cmd        <= 1'b0;
            S_Out           <= 1'b0;
            R_Out           <= 1'b0;
            Done_Out        <= 1'b0;
            Error_Out       <= 1'b0;
            Retry_Count_Out <= '0;
        end else begin
            state           <= state_nxt;
            wait_cnt        <= wait_cnt_nxt;
            attempt         <= attempt_nxt;
            target          <= target_nxt;
            hold_cmd        <= hold_cmd_nxt;
            S_Out           <= s_nxt;
            R_Out           <= r_nxt;
            Done_Out        <= done_nxt;
            Error_Out       <= error_nxt;
            Retry_Count_Out <= retry_nxt;
        end
    end

    // Next-state and next-output logic. The S/R pulse is produced on the edge
    // that enters DRIVE, so it is high for exactly the DRIVE cycle. S and R
    // are built from a target bit and its complement, so both can never be 1.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        attempt_nxt   = attempt;
        target_nxt    = target;
        hold_cmd_nxt  = hold_cmd;
        s_nxt         = 1'b0;
        r_nxt         = 1'b0;
        done_nxt      = 1'b0;
        error_nxt     = 1'b0;
        retry_nxt     = Retry_Count_Out;
        accept_target = 1'b0;

        case (Cmd_Op_In)
            OP_HOLD:   accept_target = Q_Fb_In;
            OP_RESET:  accept_target = 1'b0;
            OP_SET:    accept_target = 1'b1;
            OP_TOGGLE: accept_target = ~Q_Fb_In;
            default:   accept_target = 1'b0;
        endcase

        case (state)
            ST_IDLE: begin
                if (Cmd_Valid_In) begin
                    state_nxt    = ST_DRIVE;
                    attempt_nxt  = '0;
                    target_nxt   = accept_target;
                    hold_cmd_nxt = (Cmd_Op_In == OP_HOLD);
                    s_nxt        = (Cmd_Op_In != OP_HOLD) &&  accept_target;
                    r_nxt        = (Cmd_Op_In != OP_HOLD) && !accept_target;
                end
            end
            ST_DRIVE: begin
                state_nxt    = ST_WAIT;
                wait_cnt_nxt = SETTLE_LAST;
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_CHECK;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            ST_CHECK: begin
                if (Q_Fb_In == target) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    retry_nxt = attempt;
                end else if (attempt < RETRY_LIMIT) begin
                    state_nxt   = ST_DRIVE;
                    attempt_nxt = attempt + 3'd1;
                    s_nxt       = !hold_cmd &&  target;
                    r_nxt       = !hold_cmd && !target;
                end else begin
                    state_nxt = ST_IDLE;
                    error_nxt = 1'b1;
                    retry_nxt = attempt;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_ff_excitation_driver.sv
// Testbench for sr_ff_excitation_driver: a behavioural SR flop closes the
// loop, a table of directed commands checks pulses, latency and retry counts,
// and hand-written sequences cover reset, back-to-back and random traffic.
module tb_sr_ff_excitation_driver;

    logic       Clk_In;
    logic       Reset_In;
    logic       Cmd_Valid_In;
    logic [1:0] Cmd_Op_In;
    logic       Cmd_Ready_Out;
    logic       Q_Fb_In;
    logic       S_Out;
    logic       R_Out;
    logic       Busy_Out;
    logic       Done_Out;
    logic       Error_Out;
    logic [2:0] Retry_Count_Out;

    int compareCount;
    int failCount;

    // flop model state and feedback overrides
    logic q_model;
    logic stuck;
    int   ignorePulses;
    logic randFb;
    logic randQ;
    int   prevRetry;

    typedef struct {
        logic [1:0] op;
        logic       qInit;
        logic       stuckLow;
        int         ignore;
        int         expS;
        int         expR;
        logic       expDone;
        int         expLat;
        int         expRetry;
        logic       expQ;
    } vec_t;

    vec_t vecs[10];

    sr_ff_excitation_driver #(.SETTLE_CYCLES(2), .MAX_RETRY(3)) dut (
        .Clk_In          (Clk_In),
        .Reset_In        (Reset_In),
        .Cmd_Valid_In    (Cmd_Valid_In),
        .Cmd_Op_In       (Cmd_Op_In),
        .Cmd_Ready_Out   (Cmd_Ready_Out),
        .Q_Fb_In         (Q_Fb_In),
        .S_Out           (S_Out),
        .R_Out           (R_Out),
        .Busy_Out        (Busy_Out),
        .Done_Out        (Done_Out),
        .Error_Out       (Error_Out),
        .Retry_Count_Out (Retry_Count_Out)
    );

    // clock
    initial begin
        Clk_In = 1'b0;
        forever #5 Clk_In = ~Clk_In;
    end

    assign Q_Fb_In = randFb ? randQ : (stuck ? 1'b0 : q_model);

    // SR flop model sampling S/R on the falling edge
    always @(negedge Clk_In) begin
        if (S_Out || R_Out) begin
            if (ignorePulses > 0) ignorePulses = ignorePulses - 1;
            else if (S_Out)       q_model = 1'b1;
            else                  q_model = 1'b0;
        end
    end

    // structural invariants checked every cycle
    always @(negedge Clk_In) begin
        compareCount++;
        if ((S_Out && R_Out) || (Done_Out && Error_Out) || (Cmd_Ready_Out != !Busy_Out)) begin
            failCount++;
            $display("[TB] FAIL invariant: S=%0b R=%0b Done=%0b Error=%0b Ready=%0b Busy=%0b",
                     S_Out, R_Out, Done_Out, Error_Out, Cmd_Ready_Out, Busy_Out);
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compareCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // present a command before the edge, return 1 time unit after the accept
    // edge with valid dropped and the opcode scrambled
    task automatic applyStimulus(input logic [1:0] op);
        @(negedge Clk_In);
        Cmd_Valid_In = 1'b1;
        Cmd_Op_In    = op;
        @(posedge Clk_In);
        #1;
        Cmd_Valid_In = 1'b0;
        Cmd_Op_In    = ~op;
    endtask

    // count pulses from the accept edge until Done or Error, bounded
    task automatic runToCompletion(output int lat, output int sCnt, output int rCnt,
                                   output int doneSeen, output int errSeen);
        lat = -1; doneSeen = 0; errSeen = 0;
        sCnt = S_Out ? 1 : 0;
        rCnt = R_Out ? 1 : 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge Clk_In);
            #1;
            if (k == 1) checkOutput("retry_held", int'(Retry_Count_Out), prevRetry);
            if (Done_Out || Error_Out) begin
                lat = k;
                doneSeen = Done_Out ? 1 : 0;
                errSeen = Error_Out ? 1 : 0;
                break;
            end
            if (S_Out) sCnt++;
            if (R_Out) rCnt++;
        end
        if (lat < 0) begin
            failCount++;
            $display("[TB] FAIL completion_timeout: got no Done/Error, expected one within 100 cycles");
        end
    endtask

    initial begin
        int lat, sCnt, rCnt, doneSeen, errSeen;

        compareCount = 0; failCount = 0;
        Reset_In = 1'b0; Cmd_Valid_In = 1'b0; Cmd_Op_In = 2'b00;
        q_model = 1'b0; stuck = 1'b0; ignorePulses = 0;
        randFb = 1'b0; randQ = 1'b0; prevRetry = 0;

        //              op     q   stk ign  S  R  done lat ret  q
        vecs[0] = '{2'b10, 1'b0, 1'b0, 0, 1, 0, 1'b1,  4, 0, 1'b1};
        vecs[1] = '{2'b11, 1'b1, 1'b0, 0, 0, 1, 1'b1,  4, 0, 1'b0};
        vecs[2] = '{2'b00, 1'b0, 1'b0, 0, 0, 0, 1'b1,  4, 0, 1'b0};
        vecs[3] = '{2'b00, 1'b1, 1'b0, 0, 0, 0, 1'b1,  4, 0, 1'b1};
        vecs[4] = '{2'b01, 1'b1, 1'b0, 0, 0, 1, 1'b1,  4, 0, 1'b0};
        vecs[5] = '{2'b11, 1'b0, 1'b0, 0, 1, 0, 1'b1,  4, 0, 1'b1};
        vecs[6] = '{2'b10, 1'b1, 1'b0, 0, 1, 0, 1'b1,  4, 0, 1'b1};
        vecs[7] = '{2'b10, 1'b0, 1'b1, 0, 4, 0, 1'b0, 16, 3, 1'b0};
        vecs[8] = '{2'b10, 1'b0, 1'b0, 1, 2, 0, 1'b1,  8, 1, 1'b1};
        vecs[9] = '{2'b01, 1'b1, 1'b0, 2, 0, 3, 1'b1, 12, 2, 1'b0};

        // reset state
        #12;
        checkOutput("rst_S", S_Out, 0);
        checkOutput("rst_R", R_Out, 0);
        checkOutput("rst_ready", Cmd_Ready_Out, 1);
        checkOutput("rst_busy", Busy_Out, 0);
        checkOutput("rst_done", Done_Out, 0);
        checkOutput("rst_error", Error_Out, 0);
        checkOutput("rst_retry", int'(Retry_Count_Out), 0);
        @(negedge Clk_In);
        Reset_In = 1'b1;

        // directed table
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk_In);
            q_model      = vecs[i].qInit;
            stuck        = vecs[i].stuckLow;
            ignorePulses = vecs[i].ignore;
            applyStimulus(vecs[i].op);
            checkOutput($sformatf("v%0d_busy", i), Busy_Out, 1);
            runToCompletion(lat, sCnt, rCnt, doneSeen, errSeen);
            checkOutput($sformatf("v%0d_lat", i), lat, vecs[i].expLat);
            checkOutput($sformatf("v%0d_spulses", i), sCnt, vecs[i].expS);
            checkOutput($sformatf("v%0d_rpulses", i), rCnt, vecs[i].expR);
            checkOutput($sformatf("v%0d_done", i), doneSeen, int'(vecs[i].expDone));
            checkOutput($sformatf("v%0d_error", i), errSeen, int'(!vecs[i].expDone));
            checkOutput($sformatf("v%0d_retry", i), int'(Retry_Count_Out), vecs[i].expRetry);
            checkOutput($sformatf("v%0d_ready", i), Cmd_Ready_Out, 1);
            checkOutput($sformatf("v%0d_q", i), Q_Fb_In, int'(vecs[i].expQ));
            prevRetry = vecs[i].expRetry;
            @(posedge Clk_In);
            #1;
            checkOutput($sformatf("v%0d_pulse_end", i), int'(Done_Out || Error_Out), 0);
            stuck = 1'b0;
        end

        // reset during WAIT: everything back to reset values at once
        q_model = 1'b0;
        applyStimulus(2'b10);
        checkOutput("mw_s_pulse", S_Out, 1);
        @(posedge Clk_In); #1;
        @(posedge Clk_In); #1;
        Reset_In = 1'b0;
        #1;
        checkOutput("mw_S", S_Out, 0);
        checkOutput("mw_busy", Busy_Out, 0);
        checkOutput("mw_ready", Cmd_Ready_Out, 1);
        checkOutput("mw_retry", int'(Retry_Count_Out), 0);
        @(negedge Clk_In);
        Reset_In = 1'b1;

        // reset during DRIVE drops S asynchronously; no completion afterwards
        q_model = 1'b0;
        prevRetry = 0;
        applyStimulus(2'b10);
        checkOutput("md_s_pulse", S_Out, 1);
        #1;
        Reset_In = 1'b0;
        #1;
        checkOutput("md_S_async", S_Out, 0);
        @(negedge Clk_In);
        Reset_In = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge Clk_In); #1;
            if (Done_Out || Error_Out) doneSeen++;
        end
        checkOutput("md_no_completion", doneSeen, 0);
        checkOutput("md_ready", Cmd_Ready_Out, 1);

        // back-to-back: a command valid during the Done cycle is taken next edge
        q_model = 1'b0;
        applyStimulus(2'b10);
        runToCompletion(lat, sCnt, rCnt, doneSeen, errSeen);
        checkOutput("b2b_first_done", doneSeen, 1);
        Cmd_Valid_In = 1'b1;
        Cmd_Op_In    = 2'b01;
        @(posedge Clk_In); #1;
        Cmd_Valid_In = 1'b0;
        checkOutput("b2b_R_pulse", R_Out, 1);
        checkOutput("b2b_busy", Busy_Out, 1);
        prevRetry = 0;
        runToCompletion(lat, sCnt, rCnt, doneSeen, errSeen);
        checkOutput("b2b_second_done", doneSeen, 1);
        checkOutput("b2b_second_lat", lat, 4);

        // random commands and random feedback; invariants are checked per cycle
        randFb = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clk_In);
            Cmd_Valid_In = 1'($urandom_range(0, 1));
            Cmd_Op_In    = 2'($urandom_range(0, 3));
            randQ        = 1'($urandom_range(0, 1));
        end
        Cmd_Valid_In = 1'b0;
        randFb = 1'b0;
        for (int k = 0; k < 100 && Busy_Out; k++) @(negedge Clk_In);
        checkOutput("rand_idle", Busy_Out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
